// File: rtl/priority_resolver_n.sv
// Interrupt priority resolver: In-Service tracking, INTA handshake,
// OCW2 EOI/rotation handling for N channels with rotating priority.
module priority_resolver_n #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     irr,
  input  logic [N-1:0]     imr,
  input  logic             inta_1,
  input  logic             inta_2,
  input  logic             aeoi,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_level,
  output logic             int_req,
  output logic [IDX_W-1:0] int_index,
  output logic             spurious,
  output logic [N-1:0]     irr_clr,
  output logic [N-1:0]     isr,
  output logic [IDX_W-1:0] zero_level
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACK
  } state_e;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_e           state_q, state_d;
  logic             int_req_q, int_req_d;
  logic [IDX_W-1:0] int_index_q, int_index_d;
  logic             spurious_q, spurious_d;
  logic             ack_spur_q, ack_spur_d;
  logic [N-1:0]     irr_clr_q, irr_clr_d;
  logic [N-1:0]     isr_q, isr_d;
  logic [IDX_W-1:0] zl_q, zl_d;
  logic             aeoi_rot_q, aeoi_rot_d;

  logic [N-1:0]     cand;
  logic [N-1:0]     set_m;
  logic [N-1:0]     clr_m;
  logic [IDX_W-1:0] win, win_rel;
  logic [IDX_W-1:0] top, top_rel;
  logic             eligible;
  logic             lvl_ok;

  // Channel holding relative priority k, wrapping at N (not 2**IDX_W).
  function automatic logic [IDX_W-1:0] rot_ch(
    input logic [IDX_W-1:0] zl,
    input int               k
  );
    int c;
    c = int'(zl) + k;
    if (c >= N) c = c - N;
    return IDX_W'(c);
  endfunction

  function automatic logic [IDX_W-1:0] inc_mod(
    input logic [IDX_W-1:0] x
  );
    return (int'(x) >= N - 1) ? '0 : x + IDX_W'(1);
  endfunction

  assign cand   = irr & ~imr;
  assign lvl_ok = int'(cmd_level) < N;

  // Scan from lowest to highest priority so the last hit wins.
  always_comb begin
    win     = '0;
    win_rel = '0;
    top     = '0;
    top_rel = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand[rot_ch(zl_q, k)]) begin
        win     = rot_ch(zl_q, k);
        win_rel = IDX_W'(k);
      end
      if (isr_q[rot_ch(zl_q, k)]) begin
        top     = rot_ch(zl_q, k);
        top_rel = IDX_W'(k);
      end
    end
  end

  assign eligible = (|cand) && (~|isr_q || (win_rel < top_rel));

  always_comb begin
    state_d     = state_q;
    int_req_d   = int_req_q;
    int_index_d = int_index_q;
    spurious_d  = 1'b0;
    ack_spur_d  = ack_spur_q;
    irr_clr_d   = '0;
    set_m       = '0;
    clr_m       = '0;
    zl_d        = zl_q;
    aeoi_rot_d  = aeoi_rot_q;

    unique case (state_q)
      S_IDLE: begin
        if (eligible) begin
          state_d   = S_REQ;
          int_req_d = 1'b1;
        end
      end
      S_REQ: begin
        if (inta_1) begin
          state_d   = S_ACK;
          int_req_d = 1'b0;
          if (eligible) begin
            int_index_d    = win;
            set_m[win]     = 1'b1;
            irr_clr_d[win] = 1'b1;
            ack_spur_d     = 1'b0;
          end else begin
            int_index_d = LAST;
            spurious_d  = 1'b1;
            ack_spur_d  = 1'b1;
          end
        end
      end
      S_ACK: begin
        if (inta_2) begin
          state_d = S_IDLE;
          if (aeoi && !ack_spur_q) begin
            clr_m[int_index_q] = 1'b1;
            if (aeoi_rot_q) zl_d = inc_mod(int_index_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Commands come last so their rotation overrides an AEOI rotation.
    if (cmd_valid && lvl_ok) begin
      unique case (cmd_op)
        3'b001: begin
          if (|isr_q) clr_m[top] = 1'b1;
        end
        3'b011: clr_m[cmd_level] = 1'b1;
        3'b101: begin
          if (|isr_q) begin
            clr_m[top] = 1'b1;
            zl_d       = inc_mod(top);
          end
        end
        3'b111: begin
          clr_m[cmd_level] = 1'b1;
          zl_d             = inc_mod(cmd_level);
        end
        3'b110: zl_d = inc_mod(cmd_level);
        3'b100: aeoi_rot_d = 1'b1;
        3'b000: aeoi_rot_d = 1'b0;
        default: ;
      endcase
    end

    isr_d = (isr_q & ~clr_m) | set_m;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      int_req_q   <= 1'b0;
      int_index_q <= LAST;
      spurious_q  <= 1'b0;
      ack_spur_q  <= 1'b0;
      irr_clr_q   <= '0;
      isr_q       <= '0;
      zl_q        <= '0;
      aeoi_rot_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      int_req_q   <= int_req_d;
      int_index_q <= int_index_d;
      spurious_q  <= spurious_d;
      ack_spur_q  <= ack_spur_d;
      irr_clr_q   <= irr_clr_d;
      isr_q       <= isr_d;
      zl_q        <= zl_d;
      aeoi_rot_q  <= aeoi_rot_d;
    end
  end

  assign int_req    = int_req_q;
  assign int_index  = int_index_q;
  assign spurious   = spurious_q;
  assign irr_clr    = irr_clr_q;
  assign isr        = isr_q;
  assign zero_level = zl_q;

endmodule

// File: tb/tb_priority_resolver_n.sv
// Directed bench for priority_resolver_n: an N=8 and an N=5 instance
// driven from per-cycle vector tables plus a mid-ACK reset sequence.
module tb_priority_resolver_n;

  typedef struct {
    logic [7:0] irr;
    logic [7:0] imr;
    logic       i1;
    logic       i2;
    logic       cv;
    logic [2:0] op;
    logic [2:0] lv;
    logic       ae;
    logic       e_req;
    logic [2:0] e_idx;
    logic       e_sp;
    logic [7:0] e_clr;
    logic [7:0] e_isr;
    logic [2:0] e_zl;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] irr8, imr8;
  logic       i1_8, i2_8, ae8, cv8;
  logic [2:0] op8, lv8;
  logic       req8, sp8;
  logic [2:0] idx8, zl8;
  logic [7:0] clr8, isr8;

  logic [4:0] irr5, imr5;
  logic       i1_5, i2_5, ae5, cv5;
  logic [2:0] op5, lv5;
  logic       req5, sp5;
  logic [2:0] idx5, zl5;
  logic [4:0] clr5, isr5;

  int tests = 0;
  int fails = 0;

  vec_t q8[$];
  vec_t q5[$];

  priority_resolver_n #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .irr(irr8), .imr(imr8),
    .inta_1(i1_8), .inta_2(i2_8), .aeoi(ae8),
    .cmd_valid(cv8), .cmd_op(op8), .cmd_level(lv8),
    .int_req(req8), .int_index(idx8), .spurious(sp8),
    .irr_clr(clr8), .isr(isr8), .zero_level(zl8)
  );

  priority_resolver_n #(.N(5)) u5 (
    .clk(clk), .rst_n(rst_n),
    .irr(irr5), .imr(imr5),
    .inta_1(i1_5), .inta_2(i2_5), .aeoi(ae5),
    .cmd_valid(cv5), .cmd_op(op5), .cmd_level(lv5),
    .int_req(req5), .int_index(idx5), .spurious(sp5),
    .irr_clr(clr5), .isr(isr5), .zero_level(zl5)
  );

  function automatic vec_t mk(
    input logic [7:0] irr, input logic [7:0] imr,
    input logic i1, input logic i2,
    input logic cv, input logic [2:0] op, input logic [2:0] lv,
    input logic ae, input logic e_req, input logic [2:0] e_idx,
    input logic e_sp, input logic [7:0] e_clr,
    input logic [7:0] e_isr, input logic [2:0] e_zl
  );
    vec_t v;
    v.irr = irr; v.imr = imr; v.i1 = i1; v.i2 = i2;
    v.cv = cv; v.op = op; v.lv = lv; v.ae = ae;
    v.e_req = e_req; v.e_idx = e_idx; v.e_sp = e_sp;
    v.e_clr = e_clr; v.e_isr = e_isr; v.e_zl = e_zl;
    return v;
  endfunction

  task automatic idle_inputs();
    irr8 = '0; imr8 = '0; i1_8 = 0; i2_8 = 0; ae8 = 0;
    cv8 = 0; op8 = '0; lv8 = '0;
    irr5 = '0; imr5 = '0; i1_5 = 0; i2_5 = 0; ae5 = 0;
    cv5 = 0; op5 = '0; lv5 = '0;
  endtask

  task automatic check(
    input string name, input bit five,
    input logic e_req, input logic [2:0] e_idx, input logic e_sp,
    input logic [7:0] e_clr, input logic [7:0] e_isr,
    input logic [2:0] e_zl
  );
    logic       a_req, a_sp;
    logic [2:0] a_idx, a_zl;
    logic [7:0] a_clr, a_isr;
    if (five) begin
      a_req = req5; a_idx = idx5; a_sp = sp5;
      a_clr = {3'b000, clr5}; a_isr = {3'b000, isr5}; a_zl = zl5;
    end else begin
      a_req = req8; a_idx = idx8; a_sp = sp8;
      a_clr = clr8; a_isr = isr8; a_zl = zl8;
    end
    tests++;
    if (a_req !== e_req || a_idx !== e_idx || a_sp !== e_sp ||
        a_clr !== e_clr || a_isr !== e_isr || a_zl !== e_zl) begin
      fails++;
      $display("FAIL %s got req=%b idx=%0d sp=%b clr=%h isr=%h zl=%0d want req=%b idx=%0d sp=%b clr=%h isr=%h zl=%0d",
               name, a_req, a_idx, a_sp, a_clr, a_isr, a_zl,
               e_req, e_idx, e_sp, e_clr, e_isr, e_zl);
    end
  endtask

  task automatic apply(input string name, input bit five, input vec_t v);
    if (five) begin
      irr5 = v.irr[4:0]; imr5 = v.imr[4:0]; i1_5 = v.i1; i2_5 = v.i2;
      cv5 = v.cv; op5 = v.op; lv5 = v.lv; ae5 = v.ae;
    end else begin
      irr8 = v.irr; imr8 = v.imr; i1_8 = v.i1; i2_8 = v.i2;
      cv8 = v.cv; op8 = v.op; lv8 = v.lv; ae8 = v.ae;
    end
    @(posedge clk);
    #1;
    check(name, five, v.e_req, v.e_idx, v.e_sp, v.e_clr, v.e_isr, v.e_zl);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset8", 1'b0, 0, 3'd7, 0, 8'h00, 8'h00, 3'd0);
    check("reset5", 1'b1, 0, 3'd4, 0, 8'h00, 8'h00, 3'd0);
    rst_n = 1'b1;

    // N=5, AEOI on throughout
    q5.push_back(mk(8'h00,0,0,0,1,3'b110,3'd1,1, 0,3'd4,0,8'h00,8'h00,3'd2));
    q5.push_back(mk(8'h00,0,0,0,1,3'b100,3'd0,1, 0,3'd4,0,8'h00,8'h00,3'd2));
    q5.push_back(mk(8'h10,0,0,0,0,3'b000,3'd0,1, 1,3'd4,0,8'h00,8'h00,3'd2));
    q5.push_back(mk(8'h10,0,1,0,0,3'b000,3'd0,1, 0,3'd4,0,8'h10,8'h10,3'd2));
    q5.push_back(mk(8'h00,0,0,1,0,3'b000,3'd0,1, 0,3'd4,0,8'h00,8'h00,3'd0));
    q5.push_back(mk(8'h02,0,0,0,0,3'b000,3'd0,1, 1,3'd4,0,8'h00,8'h00,3'd0));
    q5.push_back(mk(8'h02,0,1,0,0,3'b000,3'd0,1, 0,3'd1,0,8'h02,8'h02,3'd0));
    q5.push_back(mk(8'h00,0,0,1,0,3'b000,3'd0,1, 0,3'd1,0,8'h00,8'h00,3'd2));
    q5.push_back(mk(8'h00,0,0,0,1,3'b000,3'd0,1, 0,3'd1,0,8'h00,8'h00,3'd2));
    q5.push_back(mk(8'h01,0,0,0,0,3'b000,3'd0,1, 1,3'd1,0,8'h00,8'h00,3'd2));
    q5.push_back(mk(8'h01,0,1,0,0,3'b000,3'd0,1, 0,3'd0,0,8'h01,8'h01,3'd2));
    q5.push_back(mk(8'h00,0,0,1,0,3'b000,3'd0,1, 0,3'd0,0,8'h00,8'h00,3'd2));
    q5.push_back(mk(8'h00,0,0,0,1,3'b100,3'd0,1, 0,3'd0,0,8'h00,8'h00,3'd2));
    q5.push_back(mk(8'h08,0,0,0,0,3'b000,3'd0,1, 1,3'd0,0,8'h00,8'h00,3'd2));
    q5.push_back(mk(8'h08,0,1,0,0,3'b000,3'd0,1, 0,3'd3,0,8'h08,8'h08,3'd2));
    q5.push_back(mk(8'h00,0,0,1,1,3'b110,3'd0,1, 0,3'd3,0,8'h00,8'h00,3'd1));
    q5.push_back(mk(8'h00,0,0,0,1,3'b110,3'd6,1, 0,3'd3,0,8'h00,8'h00,3'd1));

    // N=8, fully nested / rotation / spurious / collision
    q8.push_back(mk(8'h24,0,0,0,0,3'b000,3'd0,0, 1,3'd7,0,8'h00,8'h00,3'd0));
    q8.push_back(mk(8'h24,0,0,0,0,3'b000,3'd0,0, 1,3'd7,0,8'h00,8'h00,3'd0));
    q8.push_back(mk(8'h24,0,1,0,0,3'b000,3'd0,0, 0,3'd2,0,8'h04,8'h04,3'd0));
    q8.push_back(mk(8'h20,0,0,1,0,3'b000,3'd0,0, 0,3'd2,0,8'h00,8'h04,3'd0));
    q8.push_back(mk(8'h20,0,0,0,0,3'b000,3'd0,0, 0,3'd2,0,8'h00,8'h04,3'd0));
    q8.push_back(mk(8'h20,0,0,0,0,3'b000,3'd0,0, 0,3'd2,0,8'h00,8'h04,3'd0));
    q8.push_back(mk(8'h21,0,0,0,0,3'b000,3'd0,0, 1,3'd2,0,8'h00,8'h04,3'd0));
    q8.push_back(mk(8'h21,0,1,0,0,3'b000,3'd0,0, 0,3'd0,0,8'h01,8'h05,3'd0));
    q8.push_back(mk(8'h20,0,0,1,0,3'b000,3'd0,0, 0,3'd0,0,8'h00,8'h05,3'd0));
    q8.push_back(mk(8'h20,0,0,0,1,3'b001,3'd0,0, 0,3'd0,0,8'h00,8'h04,3'd0));
    q8.push_back(mk(8'h20,0,0,0,0,3'b000,3'd0,0, 0,3'd0,0,8'h00,8'h04,3'd0));
    q8.push_back(mk(8'h00,0,0,0,1,3'b011,3'd2,0, 0,3'd0,0,8'h00,8'h00,3'd0));
    q8.push_back(mk(8'h08,0,0,0,0,3'b000,3'd0,0, 1,3'd0,0,8'h00,8'h00,3'd0));
    q8.push_back(mk(8'h08,0,1,0,0,3'b000,3'd0,0, 0,3'd3,0,8'h08,8'h08,3'd0));
    q8.push_back(mk(8'h00,0,0,1,0,3'b000,3'd0,0, 0,3'd3,0,8'h00,8'h08,3'd0));
    q8.push_back(mk(8'h00,0,0,0,1,3'b101,3'd0,0, 0,3'd3,0,8'h00,8'h00,3'd4));
    q8.push_back(mk(8'h09,0,0,0,0,3'b000,3'd0,0, 1,3'd3,0,8'h00,8'h00,3'd4));
    q8.push_back(mk(8'h09,0,1,0,0,3'b000,3'd0,0, 0,3'd0,0,8'h01,8'h01,3'd4));
    q8.push_back(mk(8'h08,0,0,1,0,3'b000,3'd0,0, 0,3'd0,0,8'h00,8'h01,3'd4));
    q8.push_back(mk(8'h08,0,0,0,0,3'b000,3'd0,0, 0,3'd0,0,8'h00,8'h01,3'd4));
    q8.push_back(mk(8'h00,0,0,0,1,3'b111,3'd0,0, 0,3'd0,0,8'h00,8'h00,3'd1));
    q8.push_back(mk(8'h00,0,0,0,1,3'b110,3'd5,0, 0,3'd0,0,8'h00,8'h00,3'd6));
    q8.push_back(mk(8'hC1,8'h40,0,0,0,3'b000,3'd0,0, 1,3'd0,0,8'h00,8'h00,3'd6));
    q8.push_back(mk(8'hC1,8'h40,1,0,0,3'b000,3'd0,0, 0,3'd7,0,8'h80,8'h80,3'd6));
    q8.push_back(mk(8'h41,8'h40,0,1,0,3'b000,3'd0,0, 0,3'd7,0,8'h00,8'h80,3'd6));
    q8.push_back(mk(8'h00,0,0,0,1,3'b011,3'd7,0, 0,3'd7,0,8'h00,8'h00,3'd6));
    q8.push_back(mk(8'h08,0,0,0,0,3'b000,3'd0,0, 1,3'd7,0,8'h00,8'h00,3'd6));
    q8.push_back(mk(8'h08,0,1,0,1,3'b011,3'd3,0, 0,3'd3,0,8'h08,8'h08,3'd6));
    q8.push_back(mk(8'h00,0,0,1,0,3'b000,3'd0,0, 0,3'd3,0,8'h00,8'h08,3'd6));
    q8.push_back(mk(8'h00,0,0,1,0,3'b000,3'd0,0, 0,3'd3,0,8'h00,8'h08,3'd6));
    q8.push_back(mk(8'h01,0,1,0,0,3'b000,3'd0,0, 1,3'd3,0,8'h00,8'h08,3'd6));
    q8.push_back(mk(8'h00,0,0,0,0,3'b000,3'd0,0, 1,3'd3,0,8'h00,8'h08,3'd6));
    q8.push_back(mk(8'h00,0,1,0,0,3'b000,3'd0,0, 0,3'd7,1,8'h00,8'h08,3'd6));
    q8.push_back(mk(8'h00,0,0,1,0,3'b000,3'd0,1, 0,3'd7,0,8'h00,8'h08,3'd6));
    q8.push_back(mk(8'h00,0,0,0,0,3'b000,3'd0,0, 0,3'd7,0,8'h00,8'h08,3'd6));
    q8.push_back(mk(8'h80,0,0,0,0,3'b000,3'd0,0, 1,3'd7,0,8'h00,8'h08,3'd6));
    q8.push_back(mk(8'h80,0,1,0,0,3'b000,3'd0,0, 0,3'd7,0,8'h80,8'h88,3'd6));

    foreach (q5[i]) apply($sformatf("n5_v%0d", i), 1'b1, q5[i]);
    foreach (q8[i]) apply($sformatf("n8_v%0d", i), 1'b0, q8[i]);

    // u8 is now in ACK: reset asynchronously mid-cycle
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ack", 1'b0, 0, 3'd7, 0, 8'h00, 8'h00, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    irr8 = 8'h80;
    i2_8 = 1'b1;
    ae8  = 1'b1;
    @(posedge clk);
    #1;
    check("inta2_after_rst", 1'b0, 1, 3'd7, 0, 8'h00, 8'h00, 3'd0);
    i2_8 = 1'b0;
    @(posedge clk);
    #1;
    check("req_holds", 1'b0, 1, 3'd7, 0, 8'h00, 8'h00, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
